// File: rtl/addr_dec_pkg.sv
// addr_dec_pkg: shared FSM state type and default memory-map windows for the address decoder
package addr_dec_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP, FLT} state_t;
  localparam logic [31:0] PROG_BASE  = 32'h240;
  localparam logic [31:0] PROG_LIMIT = 32'h123F;
  localparam logic [31:0] DATA_BASE  = 32'h2000;
  localparam logic [31:0] DATA_LIMIT = 32'h2FFF;
endpackage

// File: rtl/addr_dec_match.sv
// addr_dec_match: combinational window match, lowest region index wins on overlap
module addr_dec_match #(
  parameter int NREG = 4,
  parameter int AW = 32,
  parameter logic [NREG*AW-1:0] BASE = '0,
  parameter logic [NREG*AW-1:0] LIMIT = '0
) (
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [2:0]    idx,
  output logic [AW-1:0] offset
);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    offset = '0;
    // Scan downward so the lowest matching index is the last one written
    for (int i = NREG - 1; i >= 0; i--)
      if (addr >= BASE[i*AW +: AW] && addr <= LIMIT[i*AW +: AW]) begin
        hit = 1'b1;
        idx = 3'(i);
        offset = addr - BASE[i*AW +: AW];
      end
  end
endmodule

// File: rtl/addr_decoder_multi.sv
// addr_decoder_multi: registered multi-region decoder with per-region wait states and fault strobe;
// define ADDR_DEC_FAULT_CAPTURE_EN to enable the sticky fault_addr / saturating fault_count capture.
module addr_decoder_multi #(
  parameter int NREG = 4,
  parameter int AW = 32,
  parameter logic [NREG*AW-1:0] BASE = {32'h0, 32'h0, addr_dec_pkg::DATA_BASE, addr_dec_pkg::PROG_BASE},
  parameter logic [NREG*AW-1:0] LIMIT = {32'h0, 32'h0, addr_dec_pkg::DATA_LIMIT, addr_dec_pkg::PROG_LIMIT},
  parameter logic [NREG*4-1:0] WAIT = {4'd0, 4'd0, 4'd2, 4'd0}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [AW-1:0]   req_addr,
  output logic            req_ready,
  output logic            resp_valid,
  output logic [NREG-1:0] cs,
  output logic [AW-1:0]   local_addr,
  output logic [2:0]      hit_idx,
  output logic            fault,
  input  logic            fault_clr,
  output logic [AW-1:0]   fault_addr,
  output logic [7:0]      fault_count
);
  import addr_dec_pkg::*;
  state_t state;
  logic m_hit;
  logic [2:0] m_idx, idx_q;
  logic [AW-1:0] m_off, off_q;
  logic [3:0] m_w, cnt;
  addr_dec_match #(.NREG(NREG), .AW(AW), .BASE(BASE), .LIMIT(LIMIT)) u_match (
    .addr(req_addr), .hit(m_hit), .idx(m_idx), .offset(m_off)
  );
  always_comb begin
    m_w = '0;
    for (int i = 0; i < NREG; i++) if (m_idx == 3'(i)) m_w = WAIT[i*4 +: 4];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b1;
      resp_valid <= 1'b0;
      cs <= '0;
      local_addr <= '0;
      hit_idx <= '0;
      fault <= 1'b0;
      cnt <= '0;
      idx_q <= '0;
      off_q <= '0;
    end else begin
      resp_valid <= 1'b0;
      cs <= '0;
      fault <= 1'b0;
      case (state)
        IDLE: if (req_valid) begin
          off_q <= m_off;
          idx_q <= m_idx;
          cnt <= m_w - 4'd1;
          req_ready <= 1'b0;
          state <= !m_hit ? FLT : m_w == 4'd0 ? RESP : addr_dec_pkg::WAIT;
        end
        addr_dec_pkg::WAIT: if (cnt == 4'd0) state <= RESP; else cnt <= cnt - 4'd1;
        RESP: begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b1;
          cs <= NREG'(1) << idx_q;
          local_addr <= off_q;
          hit_idx <= idx_q;
        end
        default: begin
          state <= IDLE;
          req_ready <= 1'b1;
          resp_valid <= 1'b1;
          fault <= 1'b1;
          local_addr <= '0;
          hit_idx <= '0;
        end
      endcase
    end
  end
`ifdef ADDR_DEC_FAULT_CAPTURE_EN
  logic [AW-1:0] addr_q;
  // A nonzero count doubles as the "already captured" flag; a clear on the fault edge re-arms first
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
      fault_addr <= '0;
      fault_count <= '0;
    end else begin
      if (state == IDLE && req_valid) addr_q <= req_addr;
      if (state == FLT) begin
        if (fault_clr || fault_count == 8'd0) fault_addr <= addr_q;
        fault_count <= fault_clr ? 8'd1 : fault_count + {7'd0, fault_count != 8'hFF};
      end else if (fault_clr) begin
        fault_addr <= '0;
        fault_count <= '0;
      end
    end
  end
`else
  logic unused_clr;
  assign unused_clr = fault_clr;
  assign fault_addr = '0;
  assign fault_count = '0;
`endif
endmodule

// File: tb/tb_addr_decoder_multi.sv
// tb_addr_decoder_multi: directed scoreboard bench for the default map and an overlapping-window map
module tb_addr_decoder_multi;
  typedef struct {
    logic [3:0] cs;
    logic [31:0] la;
    logic [2:0] idx;
    logic f;
    int lat;
  } exp_t;
  exp_t q[$];
  int total = 0;
  int bad = 0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_valid = 1'b0, b_valid = 1'b0, a_clr = 1'b0, b_clr = 1'b0;
  logic [31:0] a_addr = '0, b_addr = '0;
  logic a_ready, a_rv, a_f, b_ready, b_rv, b_f;
  logic [3:0] a_cs, b_cs;
  logic [31:0] a_la, b_la, a_fa, b_fa;
  logic [2:0] a_idx, b_idx;
  logic [7:0] a_fc, b_fc;
  always #5 clk = ~clk;
  addr_decoder_multi dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_addr(a_addr), .req_ready(a_ready),
    .resp_valid(a_rv), .cs(a_cs), .local_addr(a_la), .hit_idx(a_idx), .fault(a_f),
    .fault_clr(a_clr), .fault_addr(a_fa), .fault_count(a_fc)
  );
  // Region 2 overlaps region 1; region 3 is disabled (LIMIT < BASE)
  addr_decoder_multi #(
    .BASE({32'h1, 32'h2000, 32'h2000, 32'h240}),
    .LIMIT({32'h0, 32'h20FF, 32'h2FFF, 32'h123F})
  ) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_addr(b_addr), .req_ready(b_ready),
    .resp_valid(b_rv), .cs(b_cs), .local_addr(b_la), .hit_idx(b_idx), .fault(b_f),
    .fault_clr(b_clr), .fault_addr(b_fa), .fault_count(b_fc)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic xact(input bit use_b, input logic [31:0] addr, input logic [3:0] e_cs,
                      input logic [31:0] e_la, input logic [2:0] e_idx, input logic e_f,
                      input int e_lat, input bit clr);
    exp_t e;
    int k;
    q.push_back('{cs: e_cs, la: e_la, idx: e_idx, f: e_f, lat: e_lat});
    @(negedge clk);
    chk("ready_idle", use_b ? b_ready : a_ready, 1);
    if (use_b) begin b_valid = 1'b1; b_addr = addr; end
    else begin a_valid = 1'b1; a_addr = addr; end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    b_clr = clr;
    k = 0;
    while (!(use_b ? b_rv : a_rv) && k < 20) begin
      chk("ready_busy", use_b ? b_ready : a_ready, 0);
      @(negedge clk);
      b_clr = 1'b0;
      k++;
    end
    b_clr = 1'b0;
    e = q.pop_front();
    chk("latency", 64'(k), 64'(e.lat));
    chk("cs", use_b ? b_cs : a_cs, e.cs);
    chk("local_addr", use_b ? b_la : a_la, e.la);
    chk("hit_idx", use_b ? b_idx : a_idx, e.idx);
    chk("fault", use_b ? b_f : a_f, e.f);
    chk("ready_resp", use_b ? b_ready : a_ready, 1);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_ready", a_ready, 1);
    chk("rst_rv", a_rv, 0);
    chk("rst_cs", a_cs, 0);
    chk("rst_la", a_la, 0);
    chk("rst_idx", a_idx, 0);
    chk("rst_fault", a_f, 0);
    chk("rst_fa", a_fa, 0);
    chk("rst_fc", a_fc, 0);
    rst = 1'b0;
    xact(0, 32'h240, 4'b0001, 32'h0, 3'd0, 1'b0, 1, 0);
    xact(0, 32'h123F, 4'b0001, 32'hFFF, 3'd0, 1'b0, 1, 0);
    xact(0, 32'h1240, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
    xact(0, 32'h23F, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
    xact(0, 32'h2004, 4'b0010, 32'h4, 3'd1, 1'b0, 3, 0);
    xact(0, 32'h2000, 4'b0010, 32'h0, 3'd1, 1'b0, 3, 0);
    xact(0, 32'h3000, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
    xact(0, 32'h7FF, 4'b0001, 32'h5BF, 3'd0, 1'b0, 1, 0);
    xact(1, 32'h2010, 4'b0010, 32'h10, 3'd1, 1'b0, 3, 0);
    xact(1, 32'h2FFF, 4'b0010, 32'hFFF, 3'd1, 1'b0, 3, 0);
    xact(1, 32'h0, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
    xact(1, 32'h5000, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
    xact(1, 32'h6000, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
`ifdef ADDR_DEC_FAULT_CAPTURE_EN
    chk("fa_first", b_fa, 32'h0);
    chk("fc_three", b_fc, 3);
`else
    chk("fa_tied", b_fa, 0);
    chk("fc_tied", b_fc, 0);
`endif
    xact(1, 32'h7000, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 1);
`ifdef ADDR_DEC_FAULT_CAPTURE_EN
    chk("fa_after_clr", b_fa, 32'h7000);
    chk("fc_after_clr", b_fc, 1);
`else
    chk("fa_tied_clr", b_fa, 0);
    chk("fc_tied_clr", b_fc, 0);
`endif
    for (int i = 0; i < 300; i++) xact(1, 32'h8000 + i, 4'b0000, 32'h0, 3'd0, 1'b1, 1, 0);
`ifdef ADDR_DEC_FAULT_CAPTURE_EN
    chk("fc_saturate", b_fc, 255);
    chk("fa_sticky", b_fa, 32'h7000);
`else
    chk("fc_tied_sat", b_fc, 0);
    chk("fa_tied_sat", b_fa, 0);
`endif
    xact(0, 32'h2FFF, 4'b0010, 32'hFFF, 3'd1, 1'b0, 3, 0);
    @(negedge clk);
    a_valid = 1'b1;
    a_addr = 32'h2004;
    @(negedge clk);
    a_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_rv", a_rv, 0);
    chk("abort_cs", a_cs, 0);
    chk("abort_la", a_la, 0);
    chk("abort_idx", a_idx, 0);
    chk("abort_fault", a_f, 0);
    chk("abort_ready", a_ready, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("abort_no_resp", a_rv, 0);
    end
    xact(0, 32'h240, 4'b0001, 32'h0, 3'd0, 1'b0, 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
